// File: rtl/alu_sequencer_pkg.sv
// alu_sequencer_pkg: shared definitions for the ALU sequencer.
//   op_mne      - ALU opcode mnemonics driven on OP.
//   seq_state_t - sequencer FSM states.
//   ck*         - control-instruction kinds (instruction bits [7:6] when bit [8]=1).
//   *_MSB/_LSB  - instruction field positions of the 9-bit instruction word.
package alu_sequencer_pkg;

    typedef enum logic [2:0] {
        mcADD = 3'd0,
        mcSUB = 3'd1,
        mcAND = 3'd2,
        mcOR  = 3'd3,
        mcXOR = 3'd4,
        mcRXR = 3'd5,
        mcLSL = 3'd6,
        mcLSR = 3'd7
    } op_mne;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        WB     = 3'd4,
        HALTED = 3'd5
    } seq_state_t;

    localparam logic [1:0] ckBEQ  = 2'b00;
    localparam logic [1:0] ckBLT  = 2'b01;
    localparam logic [1:0] ckNOP  = 2'b10;
    localparam logic [1:0] ckHALT = 2'b11;

    localparam int INST_W     = 9;
    localparam int CLASS_BIT  = 8;   // 0 = ALU instruction, 1 = control instruction
    localparam int ALU_OP_MSB = 7;
    localparam int ALU_OP_LSB = 5;
    localparam int RS_MSB     = 4;
    localparam int RS_LSB     = 2;
    localparam int CK_MSB     = 7;
    localparam int CK_LSB     = 6;
    localparam int OFF_MSB    = 5;
    localparam int OFF_LSB    = 0;
    localparam int OFF_W      = OFF_MSB - OFF_LSB + 1;

endpackage

// File: rtl/alu_sequencer_pc_unit.sv
// alu_sequencer_pc_unit: program counter for the ALU sequencer.
//   Clk, Reset   - clock, asynchronous active-high reset (PC -> 0).
//   load_start   - restart execution at PC = 0 (highest priority).
//   take_branch  - PC <= PC + sext(offset), relative to the branch's own PC.
//   advance      - PC <= PC + 1.
//   offset       - 6-bit two's complement branch displacement.
//   PC           - current program counter; all arithmetic wraps modulo 2^PC_W.
// PC_W must be greater than the offset width (6).
module alu_sequencer_pc_unit
    import alu_sequencer_pkg::*;
#(
    parameter int PC_W = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             load_start,
    input  logic             advance,
    input  logic             take_branch,
    input  logic [OFF_W-1:0] offset,
    output logic [PC_W-1:0]  PC
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;
    logic [PC_W-1:0] offset_sext;

    assign offset_sext = {{(PC_W-OFF_W){offset[OFF_W-1]}}, offset};

    // Truncation to PC_W bits gives the modulo wrap in both directions.
    always_comb begin
        pc_d = pc_q;
        if (load_start) begin
            pc_d = '0;
        end else if (take_branch) begin
            pc_d = pc_q + offset_sext;
        end else if (advance) begin
            pc_d = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign PC = pc_q;

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle control unit for an accumulator ALU.
//   Clk, Reset     - clock, asynchronous active-high reset.
//   Start          - one-cycle pulse; restarts at PC = 0 from IDLE or HALTED only.
//   InstAddr       - instruction ROM address (the PC); ROM answers one cycle later.
//   InstIn         - 9-bit instruction, sampled in DECODE.
//   OP, RegAddrB   - ALU opcode and rs read address, updated for EXEC and held after.
//   RegWrEn        - write ALU Out to r0; high only in WB.
//   EQUALS, LT     - ALU flags, captured at the end of EXEC.
//   FlagEq, FlagLt - registered flags used by BEQ / BLT.
//   Done           - high while HALTED.
//   dbg_state      - current FSM state.
//   dbg_ir         - last instruction word latched in DECODE.
// Interface timing: Start is honoured on the rising edge where it is seen high
// in IDLE/HALTED; the ROM address presented in FETCH returns data that is
// sampled on the DECODE edge.
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int PC_W = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    output logic [PC_W-1:0]   InstAddr,
    input  logic [INST_W-1:0] InstIn,
    output logic [2:0]        OP,
    output logic [2:0]        RegAddrB,
    output logic              RegWrEn,
    input  logic              EQUALS,
    input  logic              LT,
    output logic              FlagEq,
    output logic              FlagLt,
    output logic              Done,
    output seq_state_t        dbg_state,
    output logic [INST_W-1:0] dbg_ir
);

    seq_state_t        state_q, state_d;
    logic [INST_W-1:0] ir_q, ir_d;
    op_mne             op_q, op_d;
    logic [2:0]        rs_q, rs_d;
    logic              flag_eq_q, flag_eq_d;
    logic              flag_lt_q, flag_lt_d;

    logic              load_start;
    logic              advance;
    logic              take_branch;
    logic [1:0]        ctl_kind;
    logic              branch_hit;
    logic [PC_W-1:0]   pc;

    assign ctl_kind   = InstIn[CK_MSB:CK_LSB];
    assign branch_hit = ((ctl_kind == ckBEQ) && flag_eq_q) ||
                        ((ctl_kind == ckBLT) && flag_lt_q);

    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        op_d        = op_q;
        rs_d        = rs_q;
        flag_eq_d   = flag_eq_q;
        flag_lt_d   = flag_lt_q;
        load_start  = 1'b0;
        advance     = 1'b0;
        take_branch = 1'b0;
        case (state_q)
            IDLE, HALTED: begin
                if (Start) begin
                    state_d    = FETCH;
                    load_start = 1'b1;
                end
            end
            FETCH: state_d = DECODE;
            DECODE: begin
                ir_d = InstIn;
                if (!InstIn[CLASS_BIT]) begin
                    // Latch op/rs here so they are already stable for all of EXEC.
                    op_d    = op_mne'(InstIn[ALU_OP_MSB:ALU_OP_LSB]);
                    rs_d    = InstIn[RS_MSB:RS_LSB];
                    state_d = EXEC;
                end else if (ctl_kind == ckHALT) begin
                    state_d = HALTED;
                end else begin
                    // NOP never hits, so it falls through to PC + 1.
                    take_branch = branch_hit;
                    advance     = !branch_hit;
                    state_d     = FETCH;
                end
            end
            EXEC: begin
                flag_eq_d = EQUALS;
                flag_lt_d = LT;
                state_d   = WB;
            end
            WB: begin
                advance = 1'b1;
                state_d = FETCH;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= IDLE;
            ir_q      <= '0;
            op_q      <= mcADD;
            rs_q      <= '0;
            flag_eq_q <= 1'b0;
            flag_lt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            op_q      <= op_d;
            rs_q      <= rs_d;
            flag_eq_q <= flag_eq_d;
            flag_lt_q <= flag_lt_d;
        end
    end

    alu_sequencer_pc_unit #(.PC_W(PC_W)) u_pc (
        .Clk         (Clk),
        .Reset       (Reset),
        .load_start  (load_start),
        .advance     (advance),
        .take_branch (take_branch),
        .offset      (InstIn[OFF_MSB:OFF_LSB]),
        .PC          (pc)
    );

    // Decoded from the state flop so an asynchronous reset kills a pending write at once.
    assign RegWrEn   = (state_q == WB);
    assign Done      = (state_q == HALTED);
    assign InstAddr  = pc;
    assign OP        = op_q;
    assign RegAddrB  = rs_q;
    assign FlagEq    = flag_eq_q;
    assign FlagLt    = flag_lt_q;
    assign dbg_state = state_q;
    assign dbg_ir    = ir_q;

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;
    import alu_sequencer_pkg::*;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Start = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] InstAddr;
    logic [8:0] InstIn;
    logic [2:0] OP, RegAddrB;
    logic       RegWrEn, EQUALS, LT, FlagEq, FlagLt, Done;
    seq_state_t dbg_state;
    logic [8:0] dbg_ir;

    alu_sequencer #(.PC_W(8)) dut (
        .Clk(clk), .Reset(Reset), .Start(Start), .InstAddr(InstAddr), .InstIn(InstIn),
        .OP(OP), .RegAddrB(RegAddrB), .RegWrEn(RegWrEn), .EQUALS(EQUALS), .LT(LT),
        .FlagEq(FlagEq), .FlagLt(FlagLt), .Done(Done), .dbg_state(dbg_state), .dbg_ir(dbg_ir)
    );

    // ---------------- environment: ROM, register file, ALU ----------------
    logic [8:0] rom [256];
    logic [7:0] regs [8];
    logic [7:0] set_vals [8];
    logic       set_req = 1'b0;
    logic [9:0] alu_res;

    // {lt, eq, out}
    function automatic logic [9:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] o;
        case (op)
            3'd0: o = a + b;
            3'd1: o = a - b;
            3'd2: o = a & b;
            3'd3: o = a | b;
            3'd4: o = a ^ b;
            3'd5: o = {7'd0, ^{a, b}};
            3'd6: o = a << 1;
            default: o = a >> 1;
        endcase
        return {(a < b), (o == 8'd0), o};
    endfunction

    always @(posedge clk) InstIn <= rom[InstAddr];
    always @(posedge clk) begin
        if (set_req) regs <= set_vals;
        else if (RegWrEn) regs[0] <= alu_res[7:0];
    end
    always_comb begin
        alu_res = alu_f(OP, regs[0], regs[RegAddrB]);
        EQUALS  = alu_res[8];
        LT      = alu_res[9];
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    typedef struct packed {
        seq_state_t st;
        logic [7:0] addr;
        logic       we;
        logic [2:0] op;
        logic [2:0] rs;
        logic       feq;
        logic       flt;
        logic       done;
    } exp_t;
    exp_t exp_q[$];

    // ---------------- reference model (instruction-level) ----------------
    logic [7:0] m_r [8];
    logic [2:0] m_op, m_rs;
    logic       m_feq, m_flt;

    task automatic model_reset();
        m_op = 3'd0; m_rs = 3'd0; m_feq = 1'b0; m_flt = 1'b0;
    endtask

    task automatic push_exp(input seq_state_t st, input logic [7:0] addr, input logic we, input logic done);
        exp_t e;
        e.st = st; e.addr = addr; e.we = we; e.op = m_op; e.rs = m_rs;
        e.feq = m_feq; e.flt = m_flt; e.done = done;
        exp_q.push_back(e);
    endtask

    // Cycle budget per instruction: ALU = FETCH,DECODE,EXEC,WB; control = FETCH,DECODE.
    task automatic model_fill(input int ncycles);
        logic [7:0] pc;
        logic [8:0] inst;
        logic [9:0] res;
        int         o;
        pc = 8'd0;
        exp_q.delete();
        while (exp_q.size() < ncycles) begin
            inst = rom[pc];
            push_exp(FETCH, pc, 1'b0, 1'b0);
            push_exp(DECODE, pc, 1'b0, 1'b0);
            if (!inst[8]) begin
                m_op = inst[7:5];
                m_rs = inst[4:2];
                push_exp(EXEC, pc, 1'b0, 1'b0);
                res   = alu_f(m_op, m_r[0], m_r[m_rs]);
                m_feq = res[8];
                m_flt = res[9];
                push_exp(WB, pc, 1'b1, 1'b0);
                m_r[0] = res[7:0];
                pc = pc + 8'd1;
            end else if (inst[7:6] == 2'b11) begin
                while (exp_q.size() < ncycles) push_exp(HALTED, pc, 1'b0, 1'b1);
            end else begin
                o = inst[5] ? int'(inst[5:0]) - 64 : int'(inst[5:0]);
                if ((inst[7:6] == 2'b00 && m_feq) || (inst[7:6] == 2'b01 && m_flt))
                    pc = 8'(int'(pc) + o);
                else
                    pc = pc + 8'd1;
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    function automatic logic [8:0] alu_i(input logic [2:0] op, input logic [2:0] rs);
        return {1'b0, op, rs, 2'b00};
    endfunction
    function automatic logic [8:0] ctl_i(input logic [1:0] kind, input logic [5:0] off);
        return {1'b1, kind, off};
    endfunction

    task automatic rom_clear();
        for (int i = 0; i < 256; i++) rom[i] = ctl_i(2'b11, 6'd0);
    endtask

    task automatic set_regs(input logic [7:0] r0, input logic [7:0] r1, input logic [7:0] r3, input bit rnd);
        for (int i = 0; i < 8; i++) set_vals[i] = rnd ? 8'($urandom_range(0, 255)) : 8'(i * 11);
        if (!rnd) begin set_vals[0] = r0; set_vals[1] = r1; set_vals[3] = r3; end
        m_r = set_vals;
        @(negedge clk); set_req = 1'b1;
        @(negedge clk); set_req = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        Reset = 1'b1;
        #1;
        chk("rst state", dbg_state, IDLE);
        chk("rst RegWrEn", RegWrEn, 0);
        chk("rst InstAddr", InstAddr, 0);
        chk("rst OP", OP, mcADD);
        chk("rst RegAddrB", RegAddrB, 0);
        chk("rst FlagEq", FlagEq, 0);
        chk("rst FlagLt", FlagLt, 0);
        chk("rst Done", Done, 0);
        @(negedge clk);
        Reset = 1'b0;
        model_reset();
    endtask

    task automatic pulse_start();
        @(negedge clk); Start = 1'b1;
        @(negedge clk); Start = 1'b0;
    endtask

    // Runs ncycles after Start; optional extra Start pulse in cycle start_at (must be a busy cycle).
    task automatic run_prog(input string name, input int ncycles, input int start_at, input bit chk_r0);
        exp_t e;
        model_fill(ncycles);
        pulse_start();
        for (int c = 1; c <= ncycles; c++) begin
            e = exp_q.pop_front();
            chk($sformatf("%s c%0d state", name, c), dbg_state, e.st);
            if (e.st == FETCH) chk($sformatf("%s c%0d InstAddr", name, c), InstAddr, e.addr);
            chk($sformatf("%s c%0d RegWrEn", name, c), RegWrEn, e.we);
            chk($sformatf("%s c%0d OP", name, c), OP, e.op);
            chk($sformatf("%s c%0d RegAddrB", name, c), RegAddrB, e.rs);
            chk($sformatf("%s c%0d FlagEq", name, c), FlagEq, e.feq);
            chk($sformatf("%s c%0d FlagLt", name, c), FlagLt, e.flt);
            chk($sformatf("%s c%0d Done", name, c), Done, e.done);
            Start = (c == start_at);
            @(negedge clk);
        end
        Start = 1'b0;
        if (chk_r0) chk({name, " r0"}, regs[0], m_r[0]);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        Reset = 1'b1;
        rom_clear();
        model_reset();
        repeat (2) @(negedge clk);
        do_reset();
        repeat (3) begin
            @(negedge clk);
            chk("idle hold", dbg_state, IDLE);
        end

        // ADD r1 then HALT
        rom[0] = alu_i(mcADD, 3'd1);
        rom[1] = ctl_i(ckHALT, 6'd0);
        set_regs(8'd5, 8'd3, 8'd0, 1'b0);
        run_prog("add_halt", 10, -1, 1'b1);

        // SUB r1 (equal) then BEQ +3: taken, leaves FlagEq=1 in HALTED
        rom_clear();
        rom[0] = alu_i(mcSUB, 3'd1);
        rom[1] = ctl_i(ckBEQ, 6'd3);
        set_regs(8'd7, 8'd7, 8'd0, 1'b0);
        run_prog("beq_taken", 12, -1, 1'b1);

        // Reset during EXEC of ADD r3 (flags were EQ=1 before)
        rom[0] = alu_i(mcADD, 3'd3);
        set_regs(8'd1, 8'd0, 8'd2, 1'b0);
        pulse_start();
        repeat (2) @(negedge clk);
        chk("exec reached", dbg_state, EXEC);
        Reset = 1'b1;
        @(negedge clk);
        Reset = 1'b0;
        model_reset();
        #1;
        chk("abort state", dbg_state, IDLE);
        chk("abort RegWrEn", RegWrEn, 0);
        chk("abort PC", InstAddr, 0);
        chk("abort FlagEq", FlagEq, 0);
        chk("abort Done", Done, 0);
        chk("abort r0", regs[0], 8'd1);
        rom[1] = ctl_i(ckHALT, 6'd0);
        run_prog("after_abort", 10, -1, 1'b1);

        // Reset during WB: write must be dropped asynchronously
        pulse_start();
        repeat (3) @(negedge clk);
        chk("wb RegWrEn", RegWrEn, 1);
        Reset = 1'b1;
        #1;
        chk("wb async drop", RegWrEn, 0);
        @(negedge clk);
        chk("wb r0 kept", regs[0], m_r[0]);
        Reset = 1'b0;
        model_reset();

        // BEQ taken, then restart from HALTED with Start ignored in EXEC; flags retained
        do_reset();
        rom_clear();
        rom[0] = alu_i(mcSUB, 3'd1);
        rom[1] = ctl_i(ckBEQ, 6'd3);
        set_regs(8'd7, 8'd7, 8'd0, 1'b0);
        run_prog("beq_taken2", 12, -1, 1'b1);
        run_prog("restart", 12, 3, 1'b1);

        // BEQ not taken
        do_reset();
        set_regs(8'd7, 8'd6, 8'd0, 1'b0);
        run_prog("beq_not", 12, -1, 1'b1);

        // BLT -2 wraps to 255, NOP at 255 wraps to 0, second BLT not taken
        do_reset();
        rom_clear();
        rom[0]   = alu_i(mcSUB, 3'd1);
        rom[1]   = ctl_i(ckBLT, 6'b111110);
        rom[255] = ctl_i(ckNOP, 6'd0);
        set_regs(8'd2, 8'd5, 8'd0, 1'b0);
        run_prog("blt_wrap", 20, -1, 1'b1);

        // Randomized programs
        for (int k = 0; k < 6; k++) begin
            do_reset();
            for (int i = 0; i < 256; i++) begin
                int sel;
                sel = $urandom_range(0, 19);
                if (sel < 12)      rom[i] = alu_i(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
                else if (sel < 16) rom[i] = ctl_i(2'($urandom_range(0, 1)), 6'($urandom_range(0, 63)));
                else if (sel < 19) rom[i] = ctl_i(ckNOP, 6'($urandom_range(0, 63)));
                else               rom[i] = ctl_i(ckHALT, 6'd0);
            end
            set_regs(8'd0, 8'd0, 8'd0, 1'b1);
            run_prog($sformatf("rnd%0d", k), 80, -1, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Multi-cycle control unit that feeds the combinational ALU: fetches 9-bit instructions, decodes them, and drives the ALU opcode and register-file addresses.
- Captures the ALU's EQUALS/LT flags into a flag register and resolves conditional branches from them.
- Accumulator machine: InputA always comes from r0, InputB from rs, and the result is written back to r0.
- Sits between the instruction ROM, the register file and the ALU.

Parameters:
- PC_W, 8, program-counter and instruction-address width; the PC wraps modulo 2^PC_W.

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-high; forces the IDLE state and the reset values below.
- Start  input  1  single-cycle pulse; begins execution at PC=0 when in IDLE or HALTED.
- InstAddr  output  PC_W  instruction ROM address; the ROM is synchronous, so data is valid one cycle later.
- InstIn  input  9  instruction from ROM; sampled in DECODE.
- OP  output  3  ALU opcode, using the op_mne encoding from the definitions package.
- RegAddrB  output  3  register-file read address for ALU InputB (rs). InputA is hardwired to r0 outside this block.
- RegWrEn  output  1  write-enable for the ALU Out to r0.
- EQUALS  input  1  ALU flag: Out == 0.
- LT  input  1  ALU flag: less-than.
- FlagEq  output  1  registered EQUALS.
- FlagLt  output  1  registered LT.
- Done  output  1  high while in HALTED.

Behaviour:
- Instruction format:
  - Bit [8]=0 is an ALU instruction: [7:5] = ALU op (mcADD..mcLSR), [4:2] = rs, [1:0] ignored.
  - Bit [8]=1 is a control instruction: [7:6] = kind (00 BEQ, 01 BLT, 10 NOP, 11 HALT), [5:0] = signed offset in two's complement.
- States are IDLE, FETCH, DECODE, EXEC, WB, HALTED.
- Reset values: state=IDLE, PC=0, InstAddr=0, OP=mcADD, RegAddrB=0, RegWrEn=0, FlagEq=0, FlagLt=0, Done=0.
- IDLE: on Start go to FETCH with PC=0. Otherwise hold.
- FETCH: InstAddr=PC; go to DECODE.
- DECODE: latch InstIn into the instruction register.
  - ALU instruction: go to EXEC.
  - HALT: go to HALTED; the PC is not advanced.
  - BEQ/BLT/NOP: resolve in this cycle, update PC, go to FETCH.
- EXEC (ALU only): drive OP and RegAddrB from the instruction register. At the end of the cycle capture FlagEq<=EQUALS and FlagLt<=LT. Go to WB.
- WB: RegWrEn=1 for exactly this cycle, with OP and RegAddrB still held so the ALU Out is stable. PC<=PC+1; go to FETCH.
- Branches:
  - Taken (BEQ with FlagEq=1, or BLT with FlagLt=1): PC<=PC+sext(offset), using the PC of the branch itself.
  - Not taken: PC<=PC+1.
  - Addition is modulo 2^PC_W, so wrap-around in both directions is legal.
  - Offset 0 on a taken branch loops on itself; this is legal.
- Latency: ALU instruction 4 cycles (FETCH, DECODE, EXEC, WB). Branch or NOP 2 cycles. HALT reaches HALTED 2 cycles after its FETCH.
- Flags change only in EXEC. All eight ALU ops update them, including mcRXR. Branches read flags from the most recent ALU instruction.
- RegWrEn is 0 in every state except WB. OP and RegAddrB hold their last values outside EXEC/WB.
- HALTED: Done=1. Start returns to FETCH with PC=0, clears Done, and leaves the flags unchanged.
- Start outside IDLE/HALTED is ignored.
- Reset asserted mid-instruction aborts at once and suppresses any pending write: RegWrEn drops asynchronously. Reset wins over a simultaneous Start.
- PC=2^PC_W-1 followed by PC+1 wraps to 0 with no error indication.

Decomposition:
- Shared definitions package:
  - Add enum seq_state_t {IDLE, FETCH, DECODE, EXEC, WB, HALTED}.
  - Add the control-kind constants ckBEQ, ckBLT, ckNOP, ckHALT.
  - Add the instruction field position constants.
  - Reuse the existing op_mne opcodes for OP.
- One sub-module, pc_unit: PC register, +1 incrementer and sign-extended branch adder. Inputs: Clk, Reset, load_start, advance, take_branch, offset. Output: PC.

Test Plan:
- Reset during EXEC of ADD r3 -> the next cycle shows state=IDLE, RegWrEn=0, PC=0, FlagEq=0, Done=0; Start then begins at InstAddr=0.
- ROM[0]=ADD r1 (r0=5, r1=3), ROM[1]=HALT, Start -> OP=mcADD on cycle 3, RegWrEn on cycle 4 only, InstAddr=1 on cycle 5, Done=1 from cycle 7; FlagEq=0.
- SUB r1 with r0=r1=7, then BEQ +3 at PC=1 -> FlagEq=1, next InstAddr=4. The same sequence with r1=6 -> InstAddr=2.
- BLT with offset -2 (6'b111110) at PC=1 and FlagLt=1 -> InstAddr wraps to 2^PC_W-1 (255).
- NOP at PC=255 -> next InstAddr=0.
- Start pulsed during EXEC -> ignored; no PC change. Start in HALTED -> InstAddr=0, Done falls, and FlagEq/FlagLt are retained.
